// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low segment codes
// ({g,f,e,d,c,b,a}), the all-off anode pattern and a constant log2 helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_scan_decoder.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (digit_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode display scanner with per-frame digit snapshot,
// anti-ghosting guard at the start of every slot and leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       clk_base,
  input  logic       reset,
  input  logic [3:0] num4,
  input  logic [3:0] num3,
  input  logic [3:0] num2,
  input  logic [3:0] num1,
  input  logic [3:0] dp_mask,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int            CW      = clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] snap_q;
  logic [3:0]      snap_dp_q;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       end_slot, end_frame;
  logic [3:0] zero_from;
  logic       blank;
  logic [6:0] seg_dec;

  seg_decoder u_dec (
    .digit_i (snap_q[idx_q]),
    .seg_o   (seg_dec)
  );

  always_comb begin
    end_slot  = (cnt_q == CNT_MAX);
    end_frame = end_slot && (idx_q == 2'd3);
    cnt_d     = end_slot ? '0 : cnt_q + CW'(1);
    idx_d     = end_slot ? idx_q + 2'd1 : idx_q;
  end

  // zero_from[k]: every snapshot digit from position k up to num4 is zero.
  always_comb begin
    zero_from    = '0;
    zero_from[3] = (snap_q[3] == 4'd0);
    zero_from[2] = zero_from[3] && (snap_q[2] == 4'd0);
    zero_from[1] = zero_from[2] && (snap_q[1] == 4'd0);
    zero_from[0] = zero_from[1] && (snap_q[0] == 4'd0);
    blank = blank_lz && (idx_q != 2'd0) && zero_from[idx_q] && !snap_dp_q[idx_q];
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if ((cnt_q >= GUARD_C) && !blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_dec;
      dp_d  = ~snap_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk_base) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
      snap_q    <= {num4, num3, num2, num1};
      snap_dp_q <= dp_mask;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      if (end_frame) begin
        snap_q    <= {num4, num3, num2, num1};
        snap_dp_q <= dp_mask;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV=8, GUARD=2; cycle n is the
// n-th rising edge after reset release, sampled 1 time unit after that edge.
module tb_seven_seg_scan;

  logic       clk_base = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] num4, num3, num2, num1, dp_mask;
  logic       blank_lz;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk_base = ~clk_base;

  seven_seg_scan #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk_base (clk_base),
    .reset    (reset),
    .num4     (num4),
    .num3     (num3),
    .num2     (num2),
    .num1     (num1),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_base);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic set_in(input logic [3:0] d4, d3, d2, d1, m, input logic bl);
    num4 = d4; num3 = d3; num2 = d2; num1 = d1; dp_mask = m; blank_lz = bl;
  endtask

  // Holds reset for a few edges with the given inputs, then releases it.
  task automatic start(input logic [3:0] d4, d3, d2, d1, m, input logic bl);
    reset = 1'b1;
    set_in(d4, d3, d2, d1, m, bl);
    repeat (3) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an_e,
                         input logic [6:0] seg_e, input logic dp_e);
    chk({tag, ".an"}, 32'(an), 32'(an_e));
    chk({tag, ".seg"}, 32'(seg), 32'(seg_e));
    chk({tag, ".dp"}, 32'(dp), 32'(dp_e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    repeat (2) @(posedge clk_base);
    #1;

    // Basic scan, num4..num1 = 1,2,3,4
    start(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    chk_out("reset_vals", 4'b1111, 7'h7F, 1'b1);
    run_to(1);  chk_out("basic_guard1", 4'b1111, 7'h7F, 1'b1);
    run_to(2);  chk_out("basic_guard2", 4'b1111, 7'h7F, 1'b1);
    run_to(3);  chk_out("basic_s0_first", 4'b1110, 7'h19, 1'b1);
    run_to(8);  chk_out("basic_s0_last", 4'b1110, 7'h19, 1'b1);
    run_to(9);  chk_out("basic_s1_guard", 4'b1111, 7'h7F, 1'b1);
    run_to(11); chk_out("basic_s1", 4'b1101, 7'h30, 1'b1);
    run_to(16); chk_out("basic_s1_last", 4'b1101, 7'h30, 1'b1);
    run_to(19); chk_out("basic_s2", 4'b1011, 7'h24, 1'b1);
    run_to(27); chk_out("basic_s3", 4'b0111, 7'h79, 1'b1);
    run_to(33); chk_out("basic_wrap_guard", 4'b1111, 7'h7F, 1'b1);
    run_to(35); chk_out("basic_wrap_s0", 4'b1110, 7'h19, 1'b1);

    // Snapshot coherence: inputs change mid-frame to 9,8,7,6
    start(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    run_to(10);
    set_in(4'd9, 4'd8, 4'd7, 4'd6, 4'b0000, 1'b0);
    run_to(11); chk_out("snap_old_s1", 4'b1101, 7'h30, 1'b1);
    run_to(19); chk_out("snap_old_s2", 4'b1011, 7'h24, 1'b1);
    run_to(32); chk_out("snap_old_s3", 4'b0111, 7'h79, 1'b1);
    run_to(35); chk_out("snap_new_s0", 4'b1110, 7'h02, 1'b1);
    run_to(43); chk_out("snap_new_s1", 4'b1101, 7'h78, 1'b1);
    run_to(51); chk_out("snap_new_s2", 4'b1011, 7'h00, 1'b1);
    run_to(59); chk_out("snap_new_s3", 4'b0111, 7'h10, 1'b1);

    // Leading zeros 0,0,0,5
    start(4'd0, 4'd0, 4'd0, 4'd5, 4'b0000, 1'b1);
    run_to(3); chk_out("lz_s0", 4'b1110, 7'h12, 1'b1);
    for (int c = 9; c <= 32; c++) begin
      run_to(c);
      chk("lz_blank.an", 32'(an), 32'h0000000F);
    end
    run_to(30); chk_out("lz_s3_off", 4'b1111, 7'h7F, 1'b1);

    // Leading zeros with dp on digit 2
    start(4'd0, 4'd0, 4'd0, 4'd5, 4'b0100, 1'b1);
    run_to(5);  chk_out("lzdp_s0", 4'b1110, 7'h12, 1'b1);
    run_to(12); chk_out("lzdp_s1_blank", 4'b1111, 7'h7F, 1'b1);
    run_to(19); chk_out("lzdp_s2", 4'b1011, 7'h40, 1'b0);
    run_to(24); chk_out("lzdp_s2_last", 4'b1011, 7'h40, 1'b0);
    run_to(28); chk_out("lzdp_s3_blank", 4'b1111, 7'h7F, 1'b1);

    // All zero with blanking: only digit 0 lit
    start(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    run_to(4);  chk_out("zero_s0", 4'b1110, 7'h40, 1'b1);
    run_to(13); chk_out("zero_s1", 4'b1111, 7'h7F, 1'b1);
    run_to(21); chk_out("zero_s2", 4'b1111, 7'h7F, 1'b1);
    run_to(29); chk_out("zero_s3", 4'b1111, 7'h7F, 1'b1);

    // blank_lz is live: clearing it shows the zeros in the same frame
    blank_lz = 1'b0;
    run_to(37); chk_out("zero_live_s0", 4'b1110, 7'h40, 1'b1);
    run_to(45); chk_out("zero_live_s1", 4'b1101, 7'h40, 1'b1);

    // Invalid BCD on num2, dp on digit 0
    start(4'd1, 4'd3, 4'hC, 4'd4, 4'b0001, 1'b0);
    run_to(3);  chk_out("inv_s0_dp", 4'b1110, 7'h19, 1'b0);
    run_to(11); chk_out("inv_s1_dash", 4'b1101, 7'h3F, 1'b1);
    run_to(19); chk_out("inv_s2", 4'b1011, 7'h30, 1'b1);

    // Reset mid-slot at idx2, cnt5
    start(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    run_to(21); chk_out("rst_pre", 4'b1011, 7'h24, 1'b1);
    reset = 1'b1;
    step();     chk_out("rst_forced", 4'b1111, 7'h7F, 1'b1);
    step();
    reset = 1'b0;
    cyc   = 0;
    run_to(1);  chk_out("rst_guard1", 4'b1111, 7'h7F, 1'b1);
    run_to(2);  chk_out("rst_guard2", 4'b1111, 7'h7F, 1'b1);
    run_to(3);  chk_out("rst_s0", 4'b1110, 7'h19, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
